// File: rtl/rvfpm_pkg.sv
// Shared constants and the default-width result entry for the FP issue/retire shell.
package rvfpm_pkg;

  localparam int FLEN       = 32;
  localparam int XLEN       = 32;
  localparam int DEF_ID_W   = 4;
  localparam int DEF_REG_AW = 5;

  // Result entry at the default geometry. The pipeline shell builds a
  // parameter-sized twin of this layout so that id/rd/data widths can vary.
  typedef struct packed {
    logic                  valid;
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_REG_AW-1:0] rd;
    logic                  we_frf;
    logic                  we_xreg;
    logic [FLEN-1:0]       data;
  } rvfpm_entry_t;

endpackage

// File: rtl/rvfpm_result_fifo.sv
// Circular result buffer: registered head, no fall-through, push+pop legal when full.
module rvfpm_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       ck,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr  <= {AW{1'b0}};
      rd_ptr  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  // Storage write; contents need no reset because empty gates the head downstream.
  always_ff @(posedge ck) begin
    if (push && !rst) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/rvfpm_pipe_ctrl.sv
// FP unit issue/retire shell: in-order stage array, FP scoreboard, kill-by-id, result buffer.
module rvfpm_pipe_ctrl
  import rvfpm_pkg::*;
#(
  parameter int PIPELINE_STAGES = 4,
  parameter int NUM_REGS        = 32,
  parameter int X_ID_WIDTH      = 4,
  parameter int DATA_W          = FLEN,
  parameter int RESULT_DEPTH    = 4
) (
  input  logic                                               ck,
  input  logic                                               rst,
  input  logic                                               issue_valid,
  output logic                                               issue_ready,
  input  logic [X_ID_WIDTH-1:0]                              issue_id,
  input  logic [2:0][$clog2(NUM_REGS)-1:0]                   issue_rs,
  input  logic [2:0]                                         issue_rs_used,
  input  logic [$clog2(NUM_REGS)-1:0]                        issue_rd,
  input  logic                                               issue_we_frf,
  input  logic                                               issue_we_xreg,
  input  logic [DATA_W-1:0]                                  issue_data,
  input  logic                                               kill_valid,
  input  logic [X_ID_WIDTH-1:0]                              kill_id,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [X_ID_WIDTH-1:0]                              out_id,
  output logic [$clog2(NUM_REGS)-1:0]                        out_rd,
  output logic                                               out_we_frf,
  output logic                                               out_we_xreg,
  output logic [DATA_W-1:0]                                  out_data,
  output logic [NUM_REGS-1:0]                                busy_regs,
  output logic [$clog2(PIPELINE_STAGES+RESULT_DEPTH+1)-1:0]  inflight_cnt
);

  localparam int RA_W   = $clog2(NUM_REGS);
  localparam int CNT_W  = $clog2(PIPELINE_STAGES + RESULT_DEPTH + 1);
  localparam int FCNT_W = $clog2(RESULT_DEPTH + 1);
  localparam int LAST   = PIPELINE_STAGES - 1;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [RA_W-1:0]       rd;
    logic                  we_frf;
    logic                  we_xreg;
    logic [DATA_W-1:0]     data;
  } payload_t;

  logic [PIPELINE_STAGES-1:0] stage_valid;
  payload_t                   stage_pl [PIPELINE_STAGES];
  logic [PIPELINE_STAGES-1:0] kill_hit;
  logic [PIPELINE_STAGES-1:0] live;
  logic [PIPELINE_STAGES-1:0] valid_next;
  logic [NUM_REGS-1:0]        busy_next;
  logic [CNT_W-1:0]           inflight_next;
  logic [FCNT_W-1:0]          fifo_count;
  logic                       fifo_full;
  logic                       fifo_empty;
  payload_t                   head;
  payload_t                   issue_pl;
  logic                       advance;
  logic                       hazard;
  logic                       accept;
  logic                       load;
  logic                       push;
  logic                       pop;

  assign issue_pl = '{id: issue_id, rd: issue_rd, we_frf: issue_we_frf,
                      we_xreg: issue_we_xreg, data: issue_data};

  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign advance     = !stage_valid[LAST] || !fifo_full || pop;
  assign issue_ready = !rst && advance && !hazard;
  assign accept      = issue_valid && issue_ready;
  // A same-cycle kill of the issuing id completes the handshake but creates nothing.
  assign load        = accept && !(kill_valid && (issue_id == kill_id));
  assign push        = live[LAST] && advance;

  // RAW/WAW hazard against the registered scoreboard only (no same-cycle clear bypass).
  always_comb begin
    hazard = issue_we_frf & busy_regs[issue_rd];
    for (int k = 0; k < 3; k++) begin
      hazard = hazard | (issue_rs_used[k] & busy_regs[issue_rs[k]]);
    end
  end

  // Kill matching on every valid stage, then next-state valids for the shift.
  always_comb begin
    for (int i = 0; i < PIPELINE_STAGES; i++) begin
      kill_hit[i] = stage_valid[i] & kill_valid & (stage_pl[i].id == kill_id);
      live[i]     = stage_valid[i] & ~kill_hit[i];
    end
    if (advance) begin
      valid_next[0] = load;
      for (int i = 1; i < PIPELINE_STAGES; i++) valid_next[i] = live[i-1];
    end else begin
      valid_next = live;
    end
  end

  // Scoreboard update: kills and retirement clear, a new accept sets its rd.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      logic clr;
      clr = pop & head.we_frf & (head.rd == RA_W'(r));
      for (int i = 0; i < PIPELINE_STAGES; i++) begin
        clr = clr | (kill_hit[i] & stage_pl[i].we_frf & (stage_pl[i].rd == RA_W'(r)));
      end
      busy_next[r] = (busy_regs[r] & ~clr) | (load & issue_we_frf & (issue_rd == RA_W'(r)));
    end
  end

  // Occupancy after this edge: surviving stages plus buffer after push/pop.
  always_comb begin
    inflight_next = CNT_W'(fifo_count) + CNT_W'(push) - CNT_W'(pop);
    for (int i = 0; i < PIPELINE_STAGES; i++) begin
      inflight_next = inflight_next + CNT_W'(valid_next[i]);
    end
  end

  // Control state: stage valids, scoreboard and in-flight count.
  always_ff @(posedge ck) begin
    if (rst) begin
      stage_valid  <= {PIPELINE_STAGES{1'b0}};
      busy_regs    <= {NUM_REGS{1'b0}};
      inflight_cnt <= {CNT_W{1'b0}};
    end else begin
      stage_valid  <= valid_next;
      busy_regs    <= busy_next;
      inflight_cnt <= inflight_next;
    end
  end

  // Payload shift; the whole array moves together so no bubble is squeezed out.
  always_ff @(posedge ck) begin
    if (advance) begin
      stage_pl[0] <= issue_pl;
      for (int i = 1; i < PIPELINE_STAGES; i++) stage_pl[i] <= stage_pl[i-1];
    end
  end

  rvfpm_result_fifo #(
    .WIDTH ($bits(payload_t)),
    .DEPTH (RESULT_DEPTH)
  ) u_result_fifo (
    .ck        (ck),
    .rst       (rst),
    .push      (push),
    .push_data (stage_pl[LAST]),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Head fields read as zero whenever nothing is buffered.
  assign out_id      = fifo_empty ? {X_ID_WIDTH{1'b0}} : head.id;
  assign out_rd      = fifo_empty ? {RA_W{1'b0}}       : head.rd;
  assign out_we_frf  = fifo_empty ? 1'b0               : head.we_frf;
  assign out_we_xreg = fifo_empty ? 1'b0               : head.we_xreg;
  assign out_data    = fifo_empty ? {DATA_W{1'b0}}     : head.data;

endmodule

// File: tb/tb_rvfpm_pipe_ctrl.sv
// Directed bench for rvfpm_pipe_ctrl: latency, hazards, backpressure, kill and reset.
module tb_rvfpm_pipe_ctrl;

  localparam int ST  = 4;
  localparam int NR  = 32;
  localparam int IW  = 4;
  localparam int DW  = 32;
  localparam int RDP = 4;
  localparam int RAW = 5;
  localparam int CW  = 4;

  logic               ck = 1'b0;
  logic               rst;
  logic               issue_valid;
  logic               issue_ready;
  logic [IW-1:0]      issue_id;
  logic [2:0][RAW-1:0] issue_rs;
  logic [2:0]         issue_rs_used;
  logic [RAW-1:0]     issue_rd;
  logic               issue_we_frf;
  logic               issue_we_xreg;
  logic [DW-1:0]      issue_data;
  logic               kill_valid;
  logic [IW-1:0]      kill_id;
  logic               out_valid;
  logic               out_ready;
  logic [IW-1:0]      out_id;
  logic [RAW-1:0]     out_rd;
  logic               out_we_frf;
  logic               out_we_xreg;
  logic [DW-1:0]      out_data;
  logic [NR-1:0]      busy_regs;
  logic [CW-1:0]      inflight_cnt;

  int total = 0;
  int bad   = 0;

  rvfpm_pipe_ctrl #(
    .PIPELINE_STAGES (ST),
    .NUM_REGS        (NR),
    .X_ID_WIDTH      (IW),
    .DATA_W          (DW),
    .RESULT_DEPTH    (RDP)
  ) dut (
    .ck            (ck),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_id      (issue_id),
    .issue_rs      (issue_rs),
    .issue_rs_used (issue_rs_used),
    .issue_rd      (issue_rd),
    .issue_we_frf  (issue_we_frf),
    .issue_we_xreg (issue_we_xreg),
    .issue_data    (issue_data),
    .kill_valid    (kill_valid),
    .kill_id       (kill_id),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_id        (out_id),
    .out_rd        (out_rd),
    .out_we_frf    (out_we_frf),
    .out_we_xreg   (out_we_xreg),
    .out_data      (out_data),
    .busy_regs     (busy_regs),
    .inflight_cnt  (inflight_cnt)
  );

  always #5 ck = ~ck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge ck);
  endtask

  task automatic idle();
    issue_valid   = 1'b0;
    issue_id      = '0;
    issue_rs      = '0;
    issue_rs_used = 3'b000;
    issue_rd      = '0;
    issue_we_frf  = 1'b0;
    issue_we_xreg = 1'b0;
    issue_data    = '0;
    kill_valid    = 1'b0;
    kill_id       = '0;
  endtask

  task automatic drive(input logic [IW-1:0] id, input logic [RAW-1:0] rd,
                       input logic we, input logic [DW-1:0] data);
    issue_valid   = 1'b1;
    issue_id      = id;
    issue_rd      = rd;
    issue_we_frf  = we;
    issue_we_xreg = 1'b0;
    issue_data    = data;
    issue_rs      = '0;
    issue_rs_used = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); out_ready = 1'b1;
    cyc(); cyc();
    issue_valid = 1'b1; #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b expected 0", issue_ready); end
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    total++; if (busy_regs !== 32'h0) begin bad++; $display("FAIL reset_busy: got %h expected 0", busy_regs); end
    total++; if (inflight_cnt !== 4'd0) begin bad++; $display("FAIL reset_inflight: got %0d expected 0", inflight_cnt); end
    total++; if (out_data !== 32'h0 || out_id !== 4'h0) begin bad++; $display("FAIL reset_out_fields: got id=%h data=%h expected 0", out_id, out_data); end
    rst = 1'b0; idle();
    cyc();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(4'd2, 5'd7, 1'b1, 32'h3F80_0000); #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b expected 1", issue_ready); end
    cyc(); idle();
    total++; if (busy_regs[7] !== 1'b1) begin bad++; $display("FAIL single_busy_set: got %b expected 1", busy_regs[7]); end
    total++; if (inflight_cnt !== 4'd1) begin bad++; $display("FAIL single_inflight: got %0d expected 1", inflight_cnt); end
    for (int c = 1; c < 5; c++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_out: cycle %0d got %b expected 0", c, out_valid); end
      cyc();
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid: got %b expected 1", out_valid); end
    total++; if (out_id !== 4'd2 || out_rd !== 5'd7 || out_we_frf !== 1'b1 || out_we_xreg !== 1'b0)
      begin bad++; $display("FAIL single_out_fields: got id=%0d rd=%0d frf=%b xreg=%b expected 2 7 1 0", out_id, out_rd, out_we_frf, out_we_xreg); end
    total++; if (out_data !== 32'h3F80_0000) begin bad++; $display("FAIL single_out_data: got %h expected 3f800000", out_data); end
    cyc();
    total++; if (busy_regs[7] !== 1'b0) begin bad++; $display("FAIL single_busy_clr: got %b expected 0", busy_regs[7]); end
    total++; if (out_valid !== 1'b0 || inflight_cnt !== 4'd0) begin bad++; $display("FAIL single_drained: got valid=%b cnt=%0d expected 0 0", out_valid, inflight_cnt); end
  endtask

  task automatic test_raw();
    out_ready = 1'b1;
    drive(4'd1, 5'd5, 1'b1, 32'h1111_1111);
    cyc();
    drive(4'd2, 5'd6, 1'b1, 32'h2222_2222);
    issue_rs[0] = 5'd5; issue_rs_used = 3'b001;
    for (int c = 1; c < 6; c++) begin
      #1;
      total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL raw_stall: cycle %0d got %b expected 0", c, issue_ready); end
      if (c == 5) begin
        total++; if (out_valid !== 1'b1 || out_id !== 4'd1) begin bad++; $display("FAIL raw_first_out: got valid=%b id=%0d expected 1 1", out_valid, out_id); end
      end
      cyc();
    end
    #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL raw_release: got %b expected 1", issue_ready); end
    cyc(); idle();
    cyc(); cyc(); cyc(); cyc();
    total++; if (out_valid !== 1'b1 || out_id !== 4'd2 || out_data !== 32'h2222_2222)
      begin bad++; $display("FAIL raw_second_out: got valid=%b id=%0d data=%h expected 1 2 22222222", out_valid, out_id, out_data); end
    cyc();
    total++; if (inflight_cnt !== 4'd0 || busy_regs !== 32'h0) begin bad++; $display("FAIL raw_drained: got cnt=%0d busy=%h expected 0 0", inflight_cnt, busy_regs); end
  endtask

  task automatic fill_eight();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(IW'(k), RAW'(10 + k), 1'b1, 32'hC000_0000 + k); #1;
      total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL fill_ready: issue %0d got %b expected 1", k, issue_ready); end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    fill_eight();
    drive(4'd8, 5'd18, 1'b1, 32'hC000_0008); #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready: got %b expected 0", issue_ready); end
    total++; if (inflight_cnt !== 4'd8) begin bad++; $display("FAIL bp_inflight: got %0d expected 8", inflight_cnt); end
    total++; if (busy_regs !== 32'h0003_FC00) begin bad++; $display("FAIL bp_busy: got %h expected 0003fc00", busy_regs); end
    cyc(); #1;
    total++; if (issue_ready !== 1'b0 || inflight_cnt !== 4'd8) begin bad++; $display("FAIL bp_hold: got ready=%b cnt=%0d expected 0 8", issue_ready, inflight_cnt); end
    idle(); out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (n < 8) begin
        total++; if (out_valid !== 1'b1 || out_id !== IW'(n) || out_data !== 32'hC000_0000 + n)
          begin bad++; $display("FAIL bp_drain: slot %0d got valid=%b id=%0d data=%h expected 1 %0d", n, out_valid, out_id, out_data, n); end
      end else begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_extra_out: slot %0d got %b expected 0", n, out_valid); end
      end
      cyc();
    end
    total++; if (inflight_cnt !== 4'd0 || busy_regs !== 32'h0) begin bad++; $display("FAIL bp_drained: got cnt=%0d busy=%h expected 0 0", inflight_cnt, busy_regs); end
  endtask

  task automatic test_kill();
    logic [IW-1:0] got [3];
    int n_out;
    out_ready = 1'b1;
    drive(4'd1, 5'd20, 1'b1, 32'h0000_0001); cyc();
    drive(4'd2, 5'd21, 1'b1, 32'h0000_0002); cyc();
    drive(4'd3, 5'd22, 1'b1, 32'h0000_0003); cyc();
    drive(4'd4, 5'd23, 1'b1, 32'h0000_0004); cyc();
    idle(); kill_valid = 1'b1; kill_id = 4'd3; #1;
    total++; if (inflight_cnt !== 4'd4) begin bad++; $display("FAIL kill_pre_cnt: got %0d expected 4", inflight_cnt); end
    cyc(); kill_valid = 1'b0;
    total++; if (inflight_cnt !== 4'd3) begin bad++; $display("FAIL kill_cnt: got %0d expected 3", inflight_cnt); end
    total++; if (busy_regs !== 32'h00B0_0000) begin bad++; $display("FAIL kill_busy: got %h expected 00b00000", busy_regs); end
    n_out = 0;
    for (int k = 0; k < 3; k++) got[k] = 4'hF;
    for (int n = 0; n < 12; n++) begin
      if (out_valid) begin
        if (n_out < 3) got[n_out] = out_id;
        n_out++;
      end
      cyc();
    end
    total++; if (n_out !== 3) begin bad++; $display("FAIL kill_out_count: got %0d expected 3", n_out); end
    total++; if (got[0] !== 4'd1 || got[1] !== 4'd2 || got[2] !== 4'd4)
      begin bad++; $display("FAIL kill_out_order: got %0d %0d %0d expected 1 2 4", got[0], got[1], got[2]); end
    total++; if (busy_regs !== 32'h0 || inflight_cnt !== 4'd0) begin bad++; $display("FAIL kill_drained: got busy=%h cnt=%0d expected 0 0", busy_regs, inflight_cnt); end
  endtask

  task automatic test_kill_same_and_absent();
    int n_out;
    logic [IW-1:0] first_id;
    out_ready = 1'b1;
    drive(4'd6, 5'd25, 1'b1, 32'h0000_0066);
    kill_valid = 1'b1; kill_id = 4'd6; #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL killsame_ready: got %b expected 1", issue_ready); end
    cyc(); idle();
    total++; if (busy_regs !== 32'h0 || inflight_cnt !== 4'd0) begin bad++; $display("FAIL killsame_state: got busy=%h cnt=%0d expected 0 0", busy_regs, inflight_cnt); end
    n_out = 0;
    for (int n = 0; n < 7; n++) begin
      if (out_valid) n_out++;
      cyc();
    end
    total++; if (n_out !== 0) begin bad++; $display("FAIL killsame_out: got %0d results expected 0", n_out); end
    drive(4'd9, 5'd26, 1'b1, 32'h0000_0099); cyc();
    idle(); kill_valid = 1'b1; kill_id = 4'd12; cyc();
    kill_valid = 1'b0;
    total++; if (inflight_cnt !== 4'd1 || busy_regs !== 32'h0400_0000) begin bad++; $display("FAIL killabsent_state: got cnt=%0d busy=%h expected 1 04000000", inflight_cnt, busy_regs); end
    n_out = 0; first_id = 4'hF;
    for (int n = 0; n < 10; n++) begin
      if (out_valid) begin
        if (n_out == 0) first_id = out_id;
        n_out++;
      end
      cyc();
    end
    total++; if (n_out !== 1 || first_id !== 4'd9) begin bad++; $display("FAIL killabsent_out: got count=%0d id=%0d expected 1 9", n_out, first_id); end
  endtask

  task automatic test_reset_midstream();
    fill_eight();
    idle(); #1;
    total++; if (inflight_cnt !== 4'd8) begin bad++; $display("FAIL rstmid_pre_cnt: got %0d expected 8", inflight_cnt); end
    rst = 1'b1; out_ready = 1'b1; issue_valid = 1'b1; #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready: got %b expected 0", issue_ready); end
    cyc();
    rst = 1'b0; idle();
    total++; if (out_valid !== 1'b0 || busy_regs !== 32'h0 || inflight_cnt !== 4'd0)
      begin bad++; $display("FAIL rstmid_cleared: got valid=%b busy=%h cnt=%0d expected 0 0 0", out_valid, busy_regs, inflight_cnt); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rstmid_out_data: got %h expected 0", out_data); end
    drive(4'd5, 5'd3, 1'b1, 32'h0000_ABCD); #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL rstmid_fresh_ready: got %b expected 1", issue_ready); end
    cyc(); idle();
    for (int c = 1; c < 5; c++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale_out: cycle %0d got valid=%b id=%0d expected 0", c, out_valid, out_id); end
      cyc();
    end
    total++; if (out_valid !== 1'b1 || out_id !== 4'd5 || out_rd !== 5'd3 || out_data !== 32'h0000_ABCD)
      begin bad++; $display("FAIL rstmid_fresh_out: got valid=%b id=%0d rd=%0d data=%h expected 1 5 3 0000abcd", out_valid, out_id, out_rd, out_data); end
    cyc();
    total++; if (inflight_cnt !== 4'd0 || busy_regs !== 32'h0) begin bad++; $display("FAIL rstmid_drained: got cnt=%0d busy=%h expected 0 0", inflight_cnt, busy_regs); end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; idle();
    test_reset();
    test_single();
    test_raw();
    test_backpressure();
    test_kill();
    test_kill_same_and_absent();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
